// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score keeper and its seven-segment display.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SAT
  } add_state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high {g,f,e,d,c,b,a}; non-BCD codes show blank.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD to seven-segment decoder with blanking and output polarity;
// output is {dp,g,f,e,d,c,b,a} with dp always off.
module bcd7seg
  import score_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] seg_hi;

  always_comb begin
    seg_hi = {1'b0, (blank ? SEG_BLANK : seg_pattern(bcd))};
    seg    = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
  end

endmodule

// File: rtl/score_seg_display.sv
// Event-driven BCD score keeper with a multiplexed common-anode display scanner.
// Define LZ_BLANK_EN to blank leading zeros (digit 0 is always shown).
module score_seg_display
  import score_pkg::*;
#(
  parameter int                   DIGITS         = 4,
  parameter int                   NUM_EVT        = 2,
  parameter logic [NUM_EVT*3-1:0] EVT_POS        = {3'd1, 3'd0},
  parameter int                   REFRESH_DIV    = 50000,
  parameter bit                   SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [NUM_EVT-1:0]    evt,
  output logic [4*DIGITS-1:0]   score,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  busy,
  output logic                  overflow,
  output logic                  dropped
);

  localparam int                IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int                PRE_W   = $clog2(REFRESH_DIV);
  localparam logic [2:0]        TOP_POS = 3'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF  = SEG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] s, input int k);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < DIGITS; i++)
      if (i == k) d = s[4*i +: 4];
    return d;
  endfunction

  function automatic logic [4*DIGITS-1:0] put_digit(input logic [4*DIGITS-1:0] s,
                                                     input int k, input logic [3:0] v);
    logic [4*DIGITS-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++)
      if (i == k) r[4*i +: 4] = v;
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] sat_score();
    return {DIGITS{BCD_MAX}};
  endfunction

  add_state_t          state_p0, state_d;
  logic [2:0]          ptr_p0, ptr_d, grant_pos;
  logic [NUM_EVT-1:0]  pend_p0, pend_d, grant, accept;
  logic [4*DIGITS-1:0] score_p0, score_d;
  logic                ovf_p0, ovf_d, drop_p0, drop_d, busy_p0, busy_d;
  logic [3:0]          cur_digit;

  // Fixed-priority arbiter: lowest pending channel wins.
  always_comb begin
    grant     = '0;
    grant_pos = '0;
    for (int i = NUM_EVT - 1; i >= 0; i--) begin
      if (pend_p0[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_pos = EVT_POS[3*i +: 3];
      end
    end
  end

  always_comb begin
    state_d   = state_p0;
    ptr_d     = ptr_p0;
    score_d   = score_p0;
    ovf_d     = ovf_p0;
    accept    = '0;
    cur_digit = digit_at(score_p0, int'(ptr_p0));
    case (state_p0)
      IDLE: begin
        if (|pend_p0) begin
          accept = grant;
          ptr_d  = grant_pos;
          // A saturated score swallows events without touching the digits.
          if (!ovf_p0) state_d = ADD;
        end
      end
      ADD: begin
        if (cur_digit == BCD_MAX) begin
          score_d = put_digit(score_p0, int'(ptr_p0), 4'd0);
          if (ptr_p0 == TOP_POS) state_d = SAT;
          else                   ptr_d   = ptr_p0 + 3'd1;
        end else begin
          score_d = put_digit(score_p0, int'(ptr_p0), cur_digit + 4'd1);
          state_d = IDLE;
        end
      end
      SAT: begin
        score_d = sat_score();
        ovf_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // An event arriving while its channel is still pending is lost.
    pend_d = (pend_p0 & ~accept) | (evt & ~pend_p0);
    drop_d = drop_p0 | (|(evt & pend_p0));
    if (clear) begin
      state_d = IDLE;
      score_d = '0;
      ovf_d   = 1'b0;
      pend_d  = '0;
      drop_d  = 1'b0;
    end
    busy_d = (|pend_d) | (state_d != IDLE);
  end

  // ---- stage p0: score state and event bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p0 <= IDLE;
      ptr_p0   <= '0;
      pend_p0  <= '0;
      score_p0 <= '0;
      ovf_p0   <= 1'b0;
      drop_p0  <= 1'b0;
      busy_p0  <= 1'b0;
    end else begin
      state_p0 <= state_d;
      ptr_p0   <= ptr_d;
      pend_p0  <= pend_d;
      score_p0 <= score_d;
      ovf_p0   <= ovf_d;
      drop_p0  <= drop_d;
      busy_p0  <= busy_d;
    end
  end

  logic [PRE_W-1:0]  pre_p0, pre_d;
  logic [IDX_W-1:0]  idx_p0, idx_d;
  logic              scan_p0, scan_d, wrap, blank;
  logic [3:0]        show_digit;
  logic [7:0]        seg_dec, seg_d, seg_p1;
  logic [DIGITS-1:0] an_oh, an_d, an_p1;

  always_comb begin
    wrap   = (pre_p0 == PRE_W'(REFRESH_DIV - 1));
    pre_d  = wrap ? '0 : pre_p0 + PRE_W'(1);
    scan_d = scan_p0 | wrap;
    idx_d  = idx_p0;
    // The first wrap only enables scanning; digit 0 is shown before advancing.
    if (wrap && scan_p0)
      idx_d = (idx_p0 == IDX_W'(DIGITS - 1)) ? '0 : idx_p0 + IDX_W'(1);
    show_digit = digit_at(score_p0, int'(idx_d));
    blank      = 1'b0;
`ifdef LZ_BLANK_EN
    blank = (idx_d != '0);
    for (int i = 0; i < DIGITS; i++)
      if (i >= int'(idx_d) && digit_at(score_p0, i) != 4'd0) blank = 1'b0;
`endif
    for (int i = 0; i < DIGITS; i++) an_oh[i] = (int'(idx_d) == i);
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (scan_d) begin
      an_d  = SEG_ACTIVE_LOW ? ~an_oh : an_oh;
      seg_d = seg_dec;
    end
  end

  bcd7seg #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_dec (
    .bcd  (show_digit),
    .blank(blank),
    .seg  (seg_dec)
  );

  // ---- stage p1: scan counters and registered display outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_p0  <= '0;
      idx_p0  <= '0;
      scan_p0 <= 1'b0;
      an_p1   <= AN_OFF;
      seg_p1  <= SEG_OFF;
    end else begin
      pre_p0  <= pre_d;
      idx_p0  <= idx_d;
      scan_p0 <= scan_d;
      an_p1   <= an_d;
      seg_p1  <= seg_d;
    end
  end

  assign score    = score_p0;
  assign busy     = busy_p0;
  assign overflow = ovf_p0;
  assign dropped  = drop_p0;
  assign an       = an_p1;
  assign seg      = seg_p1;

endmodule

// File: tb/tb_score_seg_display.sv
// Self-checking bench for score_seg_display: directed timing scenarios plus randomized
// event sequences checked against a decimal-arithmetic reference model.
module tb_score_seg_display;

  localparam int DIGITS      = 4;
  localparam int NUM_EVT     = 2;
  localparam int REFRESH_DIV = 4;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear   = 1'b0;
  logic [1:0]  evt     = 2'b00;
  logic [15:0] score;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        busy, overflow, dropped;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  int model_score = 0;
  bit model_ovf   = 1'b0;
  int p10 [4] = '{1, 10, 100, 1000};
  int chan_pos [2] = '{0, 1};

  score_seg_display #(
    .DIGITS        (DIGITS),
    .NUM_EVT       (NUM_EVT),
    .EVT_POS       ({3'd1, 3'd0}),
    .REFRESH_DIV   (REFRESH_DIV),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .evt     (evt),
    .score   (score),
    .seg     (seg),
    .an      (an),
    .busy    (busy),
    .overflow(overflow),
    .dropped (dropped)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Standard common-anode codes {dp,g,f,e,d,c,b,a}, dp off.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic void exp_scan(input int n, output logic [3:0] ea, output logic [7:0] es);
    logic [15:0] b;
    int d;
    bit blk;
    b  = to_bcd(model_score);
    ea = 4'hF;
    es = 8'hFF;
    if (n >= REFRESH_DIV) begin
      d = ((n / REFRESH_DIV) - 1) % DIGITS;
      ea[d] = 1'b0;
      blk = 1'b0;
`ifdef LZ_BLANK_EN
      if (d > 0) begin
        blk = 1'b1;
        for (int i = d; i < DIGITS; i++) if (b[4*i +: 4] != 4'd0) blk = 1'b0;
      end
`endif
      es = blk ? 8'hFF : seg_code(b[4*d +: 4]);
    end
  endfunction

  function automatic void model_add(input int pos);
    if (!model_ovf) begin
      model_score += p10[pos];
      if (model_score > 9999) begin
        model_score = 9999;
        model_ovf   = 1'b1;
      end
    end
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    evt     = 2'b00;
    clear   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n     = 1'b1;
    model_score = 0;
    model_ovf   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, want 0", busy, n);
    end
  endtask

  task automatic apply(input logic [1:0] m);
    @(negedge clk);
    evt = m;
    @(negedge clk);
    evt = 2'b00;
    wait_idle();
    for (int i = 0; i < 2; i++) if (m[i]) model_add(chan_pos[i]);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_score = 0;
    model_ovf   = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (score !== 16'h0000) begin failures++; $display("FAIL reset_score: got %h want 0000", score); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0 || dropped !== 1'b0) begin failures++; $display("FAIL reset_flags: got ovf=%b drop=%b want 0 0", overflow, dropped); end
    checks++; if (an !== 4'hF || seg !== 8'hFF) begin failures++; $display("FAIL reset_display: got an=%h seg=%h want F FF", an, seg); end
  endtask

  task automatic test_single();
    @(negedge clk); evt = 2'b01;
    @(negedge clk); evt = 2'b00;
    checks++; if (busy !== 1'b1 || score !== 16'h0000) begin failures++; $display("FAIL single_t1: got busy=%b score=%h want 1 0000", busy, score); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || score !== 16'h0000) begin failures++; $display("FAIL single_t2: got busy=%b score=%h want 1 0000", busy, score); end
    @(negedge clk);
    model_add(0);
    checks++; if (score !== to_bcd(model_score)) begin failures++; $display("FAIL single_t3_score: got %h want %h", score, to_bcd(model_score)); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_t3_busy: got %b want 0", busy); end
  endtask

  task automatic test_carry();
    for (int k = 0; k < 9; k++) apply(2'b10);
    for (int k = 0; k < 8; k++) apply(2'b01);
    checks++; if (score !== 16'h0099) begin failures++; $display("FAIL carry_setup: got %h want 0099", score); end
    @(negedge clk); evt = 2'b01;
    @(negedge clk); evt = 2'b00;
    repeat (3) @(negedge clk);
    checks++; if (score === 16'h0100) begin failures++; $display("FAIL carry_early: got %h at t+4, want not yet 0100", score); end
    @(negedge clk);
    model_add(0);
    checks++; if (score !== to_bcd(model_score)) begin failures++; $display("FAIL carry_t5: got %h want %h", score, to_bcd(model_score)); end
    wait_idle();
  endtask

  task automatic test_saturate();
    while (model_score + 10 <= 9999) apply(2'b10);
    while (model_score < 9999) apply(2'b01);
    checks++; if (score !== 16'h9999 || overflow !== 1'b0) begin failures++; $display("FAIL sat_setup: got %h ovf=%b want 9999 0", score, overflow); end
    @(negedge clk); evt = 2'b01;
    @(negedge clk); evt = 2'b00;
    repeat (5) @(negedge clk);
    checks++; if (overflow !== 1'b0 || score === 16'h9999) begin failures++; $display("FAIL sat_t6: got %h ovf=%b want carry in flight, ovf 0", score, overflow); end
    @(negedge clk);
    model_add(0);
    checks++; if (score !== to_bcd(model_score) || overflow !== model_ovf) begin failures++; $display("FAIL sat_t7: got %h ovf=%b want %h %b", score, overflow, to_bcd(model_score), model_ovf); end
    wait_idle();
    apply(2'b11);
    apply(2'b10);
    checks++; if (score !== to_bcd(model_score) || overflow !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL sat_hold: got %h ovf=%b busy=%b want %h 1 0", score, overflow, busy, to_bcd(model_score)); end
    pulse_clear();
    checks++; if (score !== 16'h0000 || overflow !== 1'b0 || dropped !== 1'b0) begin failures++; $display("FAIL sat_clear: got %h ovf=%b drop=%b want 0000 0 0", score, overflow, dropped); end
  endtask

  task automatic test_both();
    @(negedge clk); evt = 2'b11;
    @(negedge clk); evt = 2'b00;
    repeat (2) @(negedge clk);
    checks++; if (score !== 16'h0001) begin failures++; $display("FAIL both_order: got %h want 0001", score); end
    wait_idle();
    model_add(0); model_add(1);
    checks++; if (score !== to_bcd(model_score) || dropped !== 1'b0) begin failures++; $display("FAIL both_final: got %h drop=%b want %h 0", score, dropped, to_bcd(model_score)); end
  endtask

  task automatic test_dropped();
    pulse_clear();
    @(negedge clk); evt = 2'b01;
    @(negedge clk); evt = 2'b01;
    @(negedge clk); evt = 2'b00;
    wait_idle();
    checks++; if (dropped !== 1'b1 || score !== 16'h0001) begin failures++; $display("FAIL drop_b2b: got drop=%b score=%h want 1 0001", dropped, score); end
    pulse_clear();
    checks++; if (score !== 16'h0000 || dropped !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL drop_clear: got %h drop=%b ovf=%b want 0000 0 0", score, dropped, overflow); end
    @(negedge clk); clear = 1'b1; evt = 2'b01;
    @(negedge clk); clear = 1'b0; evt = 2'b00;
    repeat (4) @(negedge clk);
    checks++; if (score !== 16'h0000 || busy !== 1'b0) begin failures++; $display("FAIL clear_vs_evt: got %h busy=%b want 0000 0", score, busy); end
  endtask

  task automatic test_random();
    logic [1:0] m;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        pulse_clear();
      end else begin
        m = 2'($urandom_range(1, 3));
        apply(m);
      end
      checks++;
      if (score !== to_bcd(model_score) || overflow !== model_ovf || dropped !== 1'b0) begin
        failures++;
        $display("FAIL random_%0d: got %h ovf=%b drop=%b want %h %b 0", k, score, overflow, dropped, to_bcd(model_score), model_ovf);
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] ea;
    logic [7:0] es;
    do_reset();
    for (int k = 0; k < 4; k++) apply(2'b10);
    for (int k = 0; k < 2; k++) apply(2'b01);
    repeat (2) @(negedge clk);
    checks++; if (score !== 16'h0042) begin failures++; $display("FAIL scan_setup: got %h want 0042", score); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      exp_scan(edge_cnt, ea, es);
      checks++; if (an !== ea) begin failures++; $display("FAIL scan_an@%0d: got %h want %h", edge_cnt, an, ea); end
      checks++; if (seg !== es) begin failures++; $display("FAIL scan_seg@%0d: got %h want %h", edge_cnt, seg, es); end
    end
  endtask

  task automatic test_reset_midscan();
    logic [3:0] ea;
    logic [7:0] es;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (an !== 4'hF || seg !== 8'hFF) begin failures++; $display("FAIL midscan_display: got an=%h seg=%h want F FF", an, seg); end
    checks++; if (score !== 16'h0000 || busy !== 1'b0) begin failures++; $display("FAIL midscan_score: got %h busy=%b want 0000 0", score, busy); end
    model_score = 0;
    model_ovf   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_scan(edge_cnt, ea, es);
      checks++;
      if (an !== ea || seg !== es) begin
        failures++;
        $display("FAIL restart_scan@%0d: got an=%h seg=%h want %h %h", edge_cnt, an, seg, ea, es);
      end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single();
    test_carry();
    test_saturate();
    test_both();
    test_dropped();
    test_random();
    test_scan();
    test_reset_midscan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
